afu_mc_bank_model: RTL and testbench

Parametrised multi-channel AXI4 memory-controller behavioural model for simulating the AFU-to-MC path. It replaces the single-beat, one-outstanding model with one that supports INCR/FIXED bursts, byte strobes, independent AW/W acceptance, configurable read latency and any channel count. Each channel owns a private bank of 512-bit lines. It sits under afu_top on the `t_to_mc_axi4` / `t_from_mc_axi4` channel arrays, in place of the real MC.

---
 rtl/afu_mc_pkg.sv | 46 ++++
 rtl/afu_mc_bank_model.sv | 206 ++++++++++++++++++++
 tb/tb_afu_mc_bank_model.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/afu_mc_pkg.sv
// AXI4 request/response channel types shared by the AFU and the memory-controller side.
package afu_mc_pkg;

    localparam int MC_CHANNEL = 2;
    localparam int MC_ID_W    = 8;
    localparam int MC_ADDR_W  = 64;
    localparam int MC_DATA_W  = 512;
    localparam int MC_STRB_W  = MC_DATA_W / 8;
    localparam int MC_USER_W  = 1;

    typedef struct packed {
        logic                 awvalid;
        logic [MC_ID_W-1:0]   awid;
        logic [MC_ADDR_W-1:0] awaddr;
        logic [7:0]           awlen;
        logic [1:0]           awburst;
        logic                 wvalid;
        logic [MC_DATA_W-1:0] wdata;
        logic [MC_STRB_W-1:0] wstrb;
        logic                 wlast;
        logic                 bready;
        logic                 arvalid;
        logic [MC_ID_W-1:0]   arid;
        logic [MC_ADDR_W-1:0] araddr;
        logic [7:0]           arlen;
        logic [1:0]           arburst;
        logic                 rready;
    } t_to_mc_axi4;

    typedef struct packed {
        logic                 awready;
        logic                 wready;
        logic                 bvalid;
        logic [MC_ID_W-1:0]   bid;
        logic [1:0]           bresp;
        logic [MC_USER_W-1:0] buser;
        logic                 arready;
        logic                 rvalid;
        logic [MC_ID_W-1:0]   rid;
        logic [MC_DATA_W-1:0] rdata;
        logic [1:0]           rresp;
        logic                 rlast;
        logic [MC_USER_W-1:0] ruser;
    } t_from_mc_axi4;

endpackage

// File: rtl/afu_mc_bank_model.sv
// Multi-channel AXI4 memory-controller model: per-channel private bank of 512-bit lines,
// INCR/FIXED bursts with byte strobes, independent write/read FSMs, fixed read latency.
module afu_mc_bank_model
    import afu_mc_pkg::*;
#(
    parameter int NUM_CH = MC_CHANNEL,
    parameter int DEPTH  = 1024,
    parameter int RD_LAT = 2
) (
    input  logic                         afu_clk,
    input  logic                         afu_rstn,
    input  t_to_mc_axi4   [NUM_CH-1:0]   iafu2mc_to_nvme_axi4,
    output t_from_mc_axi4 [NUM_CH-1:0]   mc2iafu_from_nvme_axi4
);

    localparam int IW = $clog2(DEPTH);
    localparam logic [IW-1:0] IDX_ONE     = IW'(1);
    localparam logic [1:0]    BURST_INCR  = 2'b01;
    localparam logic [1:0]    RESP_OKAY   = 2'b00;
    localparam logic [1:0]    RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
    typedef enum logic [1:0] {R_IDLE, R_WAIT, R_DATA} r_state_e;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        t_to_mc_axi4   req;
        t_from_mc_axi4 rsp;

        logic [MC_DATA_W-1:0] bank_q [DEPTH];

        w_state_e             w_state_q;
        logic                 awready_q, wready_q, bvalid_q, werr_q;
        logic [MC_ID_W-1:0]   bid_q;
        logic [1:0]           bresp_q, wburst_q;
        logic [IW-1:0]        widx_q;
        logic [7:0]           wlen_q, wcnt_q;
        logic                 w_fire, wr_en;

        r_state_e             r_state_q;
        logic                 arready_q, rvalid_q, rlast_q;
        logic [MC_ID_W-1:0]   rid_q;
        logic [1:0]           rresp_q, rburst_q;
        logic [IW-1:0]        ridx_q;
        logic [7:0]           rlen_q, rcnt_q;
        logic [3:0]           lat_q;

        logic                 unused_addr;

        assign req         = iafu2mc_to_nvme_axi4[g];
        assign w_fire      = wready_q && req.wvalid;
        // WRAP/reserved bursts (burst[1]=1) still handshake every beat but never touch the bank
        assign wr_en       = w_fire && !wburst_q[1];
        assign unused_addr = ^{req.awaddr[MC_ADDR_W-1:6+IW], req.awaddr[5:0],
                               req.araddr[MC_ADDR_W-1:6+IW], req.araddr[5:0]};

        always_ff @(posedge afu_clk) begin
            if (wr_en) begin
                for (int unsigned b = 0; b < MC_STRB_W; b++) begin
                    if (req.wstrb[b]) begin
                        bank_q[widx_q][8*b +: 8] <= req.wdata[8*b +: 8];
                    end
                end
            end
        end

        always_ff @(posedge afu_clk or negedge afu_rstn) begin
            if (!afu_rstn) begin
                w_state_q <= W_IDLE;
                awready_q <= 1'b0;
                wready_q  <= 1'b0;
                bvalid_q  <= 1'b0;
                werr_q    <= 1'b0;
                bid_q     <= '0;
                bresp_q   <= '0;
                wburst_q  <= '0;
                widx_q    <= '0;
                wlen_q    <= '0;
                wcnt_q    <= '0;
            end else begin
                case (w_state_q)
                    W_IDLE: begin
                        awready_q <= 1'b1;
                        if (awready_q && req.awvalid) begin
                            awready_q <= 1'b0;
                            wready_q  <= 1'b1;
                            bid_q     <= req.awid;
                            widx_q    <= req.awaddr[6 +: IW];
                            wlen_q    <= req.awlen;
                            wburst_q  <= req.awburst;
                            wcnt_q    <= '0;
                            werr_q    <= req.awburst[1];
                            w_state_q <= W_DATA;
                        end
                    end
                    W_DATA: begin
                        if (w_fire) begin
                            if (wburst_q == BURST_INCR) begin
                                widx_q <= widx_q + IDX_ONE;
                            end
                            wcnt_q <= wcnt_q + 8'd1;
                            // The beat count, not wlast, closes the burst; a wlast mismatch only poisons bresp
                            if (wcnt_q == wlen_q) begin
                                wready_q  <= 1'b0;
                                bvalid_q  <= 1'b1;
                                bresp_q   <= (werr_q || !req.wlast) ? RESP_SLVERR : RESP_OKAY;
                                w_state_q <= W_RESP;
                            end else if (req.wlast) begin
                                werr_q <= 1'b1;
                            end
                        end
                    end
                    W_RESP: begin
                        if (req.bready) begin
                            bvalid_q  <= 1'b0;
                            awready_q <= 1'b1;
                            w_state_q <= W_IDLE;
                        end
                    end
                    default: w_state_q <= W_IDLE;
                endcase
            end
        end

        always_ff @(posedge afu_clk or negedge afu_rstn) begin
            if (!afu_rstn) begin
                r_state_q <= R_IDLE;
                arready_q <= 1'b0;
                rvalid_q  <= 1'b0;
                rlast_q   <= 1'b0;
                rid_q     <= '0;
                rresp_q   <= '0;
                rburst_q  <= '0;
                ridx_q    <= '0;
                rlen_q    <= '0;
                rcnt_q    <= '0;
                lat_q     <= '0;
            end else begin
                case (r_state_q)
                    R_IDLE: begin
                        arready_q <= 1'b1;
                        if (arready_q && req.arvalid) begin
                            arready_q <= 1'b0;
                            rid_q     <= req.arid;
                            ridx_q    <= req.araddr[6 +: IW];
                            rlen_q    <= req.arlen;
                            rburst_q  <= req.arburst;
                            rcnt_q    <= '0;
                            rresp_q   <= req.arburst[1] ? RESP_SLVERR : RESP_OKAY;
                            // rvalid is registered, so the wait state covers RD_LAT-1 cycles
                            if (RD_LAT == 1) begin
                                rvalid_q  <= 1'b1;
                                rlast_q   <= (req.arlen == 8'd0);
                                r_state_q <= R_DATA;
                            end else begin
                                lat_q     <= 4'(RD_LAT - 1);
                                r_state_q <= R_WAIT;
                            end
                        end
                    end
                    R_WAIT: begin
                        lat_q <= lat_q - 4'd1;
                        if (lat_q == 4'd1) begin
                            rvalid_q  <= 1'b1;
                            rlast_q   <= (rlen_q == 8'd0);
                            r_state_q <= R_DATA;
                        end
                    end
                    R_DATA: begin
                        if (req.rready) begin
                            if (rcnt_q == rlen_q) begin
                                rvalid_q  <= 1'b0;
                                rlast_q   <= 1'b0;
                                r_state_q <= R_IDLE;
                            end else begin
                                rcnt_q  <= rcnt_q + 8'd1;
                                rlast_q <= ((rcnt_q + 8'd1) == rlen_q);
                                if (rburst_q == BURST_INCR) begin
                                    ridx_q <= ridx_q + IDX_ONE;
                                end
                            end
                        end
                    end
                    default: r_state_q <= R_IDLE;
                endcase
            end
        end

        always_comb begin
            rsp         = '0;
            rsp.awready = awready_q;
            rsp.wready  = wready_q;
            rsp.bvalid  = bvalid_q;
            rsp.bid     = bid_q;
            rsp.bresp   = bresp_q;
            rsp.arready = arready_q;
            rsp.rvalid  = rvalid_q;
            rsp.rid     = rid_q;
            rsp.rresp   = rresp_q;
            rsp.rlast   = rlast_q;
            rsp.rdata   = rvalid_q ? bank_q[ridx_q] : '0;
        end

        assign mc2iafu_from_nvme_axi4[g] = rsp;
    end

endmodule

// File: tb/tb_afu_mc_bank_model.sv
// Self-checking bench for afu_mc_bank_model: directed table, hand sequences, random traffic vs. a line-array model.
module tb_afu_mc_bank_model;
    import afu_mc_pkg::*;

    localparam int NCH    = MC_CHANNEL;
    localparam int DEPTH  = 16;
    localparam int RD_LAT = 2;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    t_to_mc_axi4   [NCH-1:0] req;
    t_from_mc_axi4 [NCH-1:0] rsp;

    logic [511:0] mdl [NCH][DEPTH];
    int n_chk  = 0;
    int n_pass = 0;
    int id_ctr = 1;

    typedef struct {
        int           ch;
        logic [63:0]  addr;
        int           len;
        logic [1:0]   burst;
        logic [63:0]  strb;
        logic [511:0] base;
        int           early;
        logic [1:0]   bresp;
    } vec_t;

    vec_t vt [8];

    always #5 clk = ~clk;

    afu_mc_bank_model #(.NUM_CH(NCH), .DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .afu_clk                (clk),
        .afu_rstn               (rstn),
        .iafu2mc_to_nvme_axi4   (req),
        .mc2iafu_from_nvme_axi4 (rsp)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [511:0] got, input logic [511:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic timeout(input string nm);
        n_chk++;
        $display("FAIL %s: got timeout expected DUT response", nm);
    endtask

    function automatic int line_of(input logic [63:0] addr, input int n, input logic [1:0] burst);
        int base;
        base = int'((addr >> 6) % DEPTH);
        return (burst == 2'b01) ? (base + n) % DEPTH : base;
    endfunction

    function automatic logic [511:0] rnd512();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom();
        return r;
    endfunction

    // early >= 0: wlast is driven on that beat only instead of the final one
    task automatic wr(input int ch, input logic [63:0] addr, input int len, input logic [1:0] burst,
                      input logic [63:0] strb, input logic [511:0] base, input int early,
                      input logic [1:0] exp_bresp);
        int g;
        int ln;
        logic [7:0] id;
        logic [511:0] d;
        id = 8'(id_ctr);
        id_ctr++;
        req[ch].awid    = id;
        req[ch].awaddr  = addr;
        req[ch].awlen   = 8'(len);
        req[ch].awburst = burst;
        req[ch].awvalid = 1'b1;
        g = 0;
        while (!rsp[ch].awready && g < 200) begin tick; g++; end
        if (g >= 200) timeout("aw_handshake");
        tick;
        req[ch].awvalid = 1'b0;
        for (int n = 0; n <= len; n++) begin
            d = base + 512'(n);
            req[ch].wvalid = 1'b1;
            req[ch].wdata  = d;
            req[ch].wstrb  = strb;
            req[ch].wlast  = (early >= 0) ? (n == early) : (n == len);
            g = 0;
            while (!rsp[ch].wready && g < 200) begin tick; g++; end
            if (g >= 200) timeout("w_handshake");
            tick;
            if (burst[1] == 1'b0) begin
                ln = line_of(addr, n, burst);
                for (int b = 0; b < 64; b++)
                    if (strb[b]) mdl[ch][ln][8*b +: 8] = d[8*b +: 8];
            end
            chk("bvalid_timing", rsp[ch].bvalid, n == len);
        end
        req[ch].wvalid = 1'b0;
        req[ch].wlast  = 1'b0;
        req[ch].bready = 1'b1;
        g = 0;
        while (!rsp[ch].bvalid && g < 200) begin tick; g++; end
        if (g >= 200) timeout("b_response");
        chk("bid", rsp[ch].bid, id);
        chk("bresp", rsp[ch].bresp, exp_bresp);
        tick;
        req[ch].bready = 1'b0;
        chk("awready_after_b", rsp[ch].awready, 1'b1);
    endtask

    task automatic rd(input int ch, input logic [63:0] addr, input int len, input logic [1:0] burst,
                      input bit bp, output int lat);
        int g;
        int beat;
        int k;
        bit first;
        logic [7:0] id;
        id = 8'(id_ctr);
        id_ctr++;
        req[ch].arid    = id;
        req[ch].araddr  = addr;
        req[ch].arlen   = 8'(len);
        req[ch].arburst = burst;
        req[ch].arvalid = 1'b1;
        g = 0;
        while (!rsp[ch].arready && g < 200) begin tick; g++; end
        if (g >= 200) timeout("ar_handshake");
        tick;
        req[ch].arvalid = 1'b0;
        req[ch].rready  = 1'b1;
        k = 1; beat = 0; first = 1'b1; lat = -1; g = 0;
        while (beat <= len && g < 1000) begin
            if (rsp[ch].rvalid) begin
                if (first) begin lat = k; first = 1'b0; end
                if (burst[1] == 1'b0)
                    chk("rdata", rsp[ch].rdata, mdl[ch][line_of(addr, beat, burst)]);
                chk("rid", rsp[ch].rid, id);
                chk("rlast", rsp[ch].rlast, beat == len);
                chk("rresp", rsp[ch].rresp, burst[1] ? 2'b10 : 2'b00);
                if (req[ch].rready) beat++;
            end
            tick;
            k++; g++;
            if (bp && !first) req[ch].rready = ~req[ch].rready;
        end
        if (g >= 1000) timeout("r_beats");
        req[ch].rready = 1'b0;
        chk("rvalid_after_last", rsp[ch].rvalid, 1'b0);
    endtask

    initial begin
        int lat;
        int g;
        int stale;

        req = '0;
        vt[0] = '{ch:0, addr:64'h40,        len:0, burst:2'b01, strb:{64{1'b1}},
                  base:{64{8'hA5}}, early:-1, bresp:2'b00};
        vt[1] = '{ch:1, addr:64'h100,       len:3, burst:2'b01, strb:{64{1'b1}},
                  base:512'd1, early:-1, bresp:2'b00};
        vt[2] = '{ch:0, addr:64'(15*64),    len:0, burst:2'b01, strb:{64{1'b1}},
                  base:{64{8'hFF}}, early:-1, bresp:2'b00};
        vt[3] = '{ch:0, addr:64'(15*64),    len:1, burst:2'b01, strb:64'h1,
                  base:{64{8'h3C}}, early:-1, bresp:2'b00};
        vt[4] = '{ch:1, addr:64'h80,        len:1, burst:2'b10, strb:{64{1'b1}},
                  base:{64{8'h77}}, early:-1, bresp:2'b10};
        vt[5] = '{ch:0, addr:64'(6*64),     len:2, burst:2'b01, strb:{64{1'b1}},
                  base:{64{8'h11}}, early:1, bresp:2'b10};
        vt[6] = '{ch:1, addr:64'(8*64 + 5), len:3, burst:2'b00, strb:{16{4'h5}},
                  base:{64{8'h90}}, early:-1, bresp:2'b00};
        vt[7] = '{ch:0, addr:64'hF000_00C0, len:0, burst:2'b11, strb:{64{1'b1}},
                  base:{64{8'hEE}}, early:-1, bresp:2'b10};

        repeat (3) tick;
        for (int c = 0; c < NCH; c++) chk("reset_outputs_zero", rsp[c] == '0, 1'b1);
        rstn = 1'b1;
        chk("awready_before_edge", rsp[0].awready, 1'b0);
        tick;
        for (int c = 0; c < NCH; c++) begin
            chk("awready_after_reset", rsp[c].awready, 1'b1);
            chk("arready_after_reset", rsp[c].arready, 1'b1);
        end

        // Fill every line of every channel so no read ever touches an unwritten line
        for (int c = 0; c < NCH; c++)
            wr(c, 64'h0, DEPTH - 1, 2'b01, {64{1'b1}}, {16{32'h5A5A_0000 + 32'(c)}}, -1, 2'b00);

        for (int i = 0; i < 8; i++) begin
            wr(vt[i].ch, vt[i].addr, vt[i].len, vt[i].burst, vt[i].strb, vt[i].base,
               vt[i].early, vt[i].bresp);
            rd(vt[i].ch, vt[i].addr, vt[i].len, 2'b01, 1'b0, lat);
        end

        rd(0, 64'h40, 0, 2'b01, 1'b0, lat);
        chk("rd_latency", lat, RD_LAT);
        chk("line1_a5", mdl[0][1], {64{8'hA5}});
        rd(1, 64'h100, 3, 2'b01, 1'b1, lat);
        rd(0, 64'(15*64), 1, 2'b01, 1'b0, lat);
        rd(1, 64'h80, 1, 2'b10, 1'b0, lat);

        for (int c = 0; c < NCH; c++) begin
            automatic int cc = c;
            fork
                wr(cc, 64'(5*64), 2, 2'b01, {64{1'b1}}, {16{32'hBEEF_0000 + 32'(cc * 16)}}, -1, 2'b00);
            join_none
        end
        wait fork;
        for (int c = 0; c < NCH; c++) rd(c, 64'(5*64), 2, 2'b01, 1'b0, lat);

        for (int i = 0; i < 40; i++) begin
            int ch;
            int len;
            logic [1:0] burst;
            logic [63:0] addr;
            ch    = $urandom_range(0, NCH - 1);
            len   = $urandom_range(0, 5);
            burst = 2'($urandom_range(0, 1));
            addr  = {32'($urandom()), 22'($urandom()), 4'($urandom_range(0, DEPTH - 1)), 6'($urandom())};
            if ($urandom_range(0, 1) == 1)
                wr(ch, addr, len, burst, {32'($urandom()), 32'($urandom())}, rnd512(), -1, 2'b00);
            else
                rd(ch, addr, len, burst, 1'($urandom_range(0, 1)), lat);
        end

        // Reset in the middle of a read data phase
        req[0].arid    = 8'h5E;
        req[0].araddr  = 64'h0;
        req[0].arlen   = 8'd7;
        req[0].arburst = 2'b01;
        req[0].arvalid = 1'b1;
        g = 0;
        while (!rsp[0].arready && g < 200) begin tick; g++; end
        if (g >= 200) timeout("rst_ar_handshake");
        tick;
        req[0].arvalid = 1'b0;
        req[0].rready  = 1'b1;
        g = 0;
        while (!rsp[0].rvalid && g < 200) begin tick; g++; end
        if (g >= 200) timeout("rst_first_beat");
        tick;
        tick;
        rstn = 1'b0;
        #1;
        chk("rvalid_in_reset", rsp[0].rvalid, 1'b0);
        chk("rlast_in_reset", rsp[0].rlast, 1'b0);
        chk("arready_in_reset", rsp[0].arready, 1'b0);
        req[0].rready = 1'b0;
        repeat (2) tick;
        rstn = 1'b1;
        tick;
        chk("arready_after_release", rsp[0].arready, 1'b1);
        chk("awready_after_release", rsp[0].awready, 1'b1);
        req[0].rready = 1'b1;
        stale = 0;
        for (int i = 0; i < 6; i++) begin
            if (rsp[0].rvalid) stale++;
            tick;
        end
        req[0].rready = 1'b0;
        chk("stale_beats", stale, 0);
        rd(0, 64'h0, DEPTH - 1, 2'b01, 1'b0, lat);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
